// File: rtl/sifh_pkg.sv
// Shared definitions for the SiFH acquisition scheduler: frame-phase encoding,
// parameter defaults and the RAM address-width derivation.
package sifh_pkg;

  localparam int DEF_NPIX     = 4;
  localparam int DEF_NP       = 10;
  localparam int DEF_PEAK_MAX = 8;
  localparam int DEF_ACQ_NUM  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SCAN  = 3'd4,
    ST_DONE  = 3'd5
  } sifh_state_e;

  // Histogram RAM address is {pixel, bin}.
  function automatic int calc_aw(input int npix, input int np);
    return $clog2(npix) + np;
  endfunction

endpackage

// File: rtl/sifh_rr_arb.sv
// Round-robin arbiter with one-hot grant; the pointer moves past the winner on
// every grant and is forced back to pixel 0 while i_clr is high.
module sifh_rr_arb
  import sifh_pkg::*;
#(
  parameter int  NPIX = DEF_NPIX,
  localparam int PW   = $clog2(NPIX)
) (
  input  logic            clk,
  input  logic            res,
  input  logic            i_clr,
  input  logic [NPIX-1:0] i_req,
  output logic [NPIX-1:0] o_gnt,
  output logic [PW-1:0]   o_gnt_idx,
  output logic            o_gnt_vld
);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic          w_found;
  logic [PW-1:0] w_win;

  // First asserted request at or after the pointer; PW-bit wrap gives mod NPIX.
  always_comb begin
    w_idx   = '0;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NPIX; i++) begin
      w_idx = r_ptr + PW'(i);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign o_gnt_vld = w_found;
  assign o_gnt_idx = w_win;
  assign o_gnt     = w_found ? (NPIX'(1) << w_win) : '0;

  always_ff @(posedge clk) begin
    if (res || i_clr) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_win + PW'(1);
    end
  end

endmodule

// File: rtl/sifh_acq_sched.sv
// Frame sequencer for the shared histogram RAM: clear, arbitrated saturating
// accumulation with write forwarding, drain, then per-pixel peak scan.
module sifh_acq_sched
  import sifh_pkg::*;
#(
  parameter int  NPIX     = DEF_NPIX,
  parameter int  NP       = DEF_NP,
  parameter int  PEAK_MAX = DEF_PEAK_MAX,
  parameter int  ACQ_NUM  = DEF_ACQ_NUM,
  localparam int PW       = $clog2(NPIX),
  localparam int AW       = calc_aw(NPIX, NP)
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 start,
  input  logic                 laser_sync,
  input  logic [NPIX-1:0]      req,
  input  logic [NPIX*NP-1:0]   ts,
  output logic [NPIX-1:0]      gnt,
  output logic [AW-1:0]        ram_waddr,
  output logic [PEAK_MAX-1:0]  ram_wdata,
  output logic                 ram_we,
  output logic [AW-1:0]        ram_raddr,
  output logic                 ram_re,
  input  logic [PEAK_MAX-1:0]  ram_rdata,
  output logic                 peak_valid,
  output logic [PW-1:0]        peak_pix,
  output logic [NP-1:0]        peak_bin,
  output logic [PEAK_MAX-1:0]  peak_cnt,
  output logic                 busy,
  output logic                 done
);

  localparam int                LW   = $clog2(ACQ_NUM + 1);
  localparam logic [PEAK_MAX-1:0] CMAX = '1;

  function automatic logic [PEAK_MAX-1:0] sat_inc(input logic [PEAK_MAX-1:0] v);
    return (v == CMAX) ? v : v + PEAK_MAX'(1);
  endfunction

  sifh_state_e r_state, w_state_nxt;

  logic [AW-1:0]       r_seq;
  logic                r_scan_end;
  logic [LW-1:0]       r_lcnt;
  logic                w_term;
  logic                w_arb_en;
  logic [NPIX-1:0]     w_gnt;
  logic [PW-1:0]       w_gidx;
  logic                w_s1_vld;
  logic [NP-1:0]       w_ts [NPIX];
  logic [AW-1:0]       w_s1_addr;

  logic                r_vld_p1;
  logic [AW-1:0]       r_addr_p1;
  logic                r_fwd_vld_p1;
  logic [PEAK_MAX-1:0] r_fwd_data_p1;
  logic [PEAK_MAX-1:0] w_old;
  logic [PEAK_MAX-1:0] w_inc;

  logic                w_scan_rd;
  logic                r_scan_vld_p1;
  logic [AW-1:0]       r_scan_addr_p1;
  logic [NP-1:0]       w_scan_bin;
  logic                w_take;
  logic [PEAK_MAX-1:0] w_cand_cnt;
  logic [NP-1:0]       w_cand_bin;
  logic                w_pix_end;
  logic [PEAK_MAX-1:0] r_max_cnt;
  logic [NP-1:0]       r_max_bin;
  logic                r_peak_vld_p2;
  logic [PW-1:0]       r_peak_pix_p2;
  logic [NP-1:0]       r_peak_bin_p2;
  logic [PEAK_MAX-1:0] r_peak_cnt_p2;

  assign w_term   = (r_state == ST_ACCUM) && laser_sync && (r_lcnt == LW'(ACQ_NUM - 1));
  assign w_arb_en = (r_state == ST_ACCUM) && !w_term;

  sifh_rr_arb #(.NPIX(NPIX)) u_arb (
    .clk       (clk),
    .res       (res),
    .i_clr     (r_state == ST_CLEAR),
    .i_req     (req & {NPIX{w_arb_en}}),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gidx),
    .o_gnt_vld (w_s1_vld)
  );

  always_comb begin
    for (int i = 0; i < NPIX; i++) begin
      w_ts[i] = ts[i*NP +: NP];
    end
  end

  // ---- p0: grant and read of {pix, ts[pix]} ----
  assign w_s1_addr = {w_gidx, w_ts[w_gidx]};

  // ---- p1: saturating increment; RAM is read-first, so a same-address
  // write in the grant cycle must be forwarded ----
  assign w_old = r_fwd_vld_p1 ? r_fwd_data_p1 : ram_rdata;
  assign w_inc = sat_inc(w_old);

  // ---- scan p1: rdata for the read issued last cycle ----
  assign w_scan_rd  = (r_state == ST_SCAN) && !r_scan_end;
  assign w_scan_bin = r_scan_addr_p1[NP-1:0];
  assign w_take     = (w_scan_bin == '0) || (ram_rdata > r_max_cnt);
  assign w_cand_cnt = w_take ? ram_rdata : r_max_cnt;
  assign w_cand_bin = w_take ? w_scan_bin : r_max_bin;
  assign w_pix_end  = r_scan_vld_p1 && (&w_scan_bin);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (&r_seq) w_state_nxt = ST_ACCUM;
      ST_ACCUM: if (w_term) w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_SCAN;
      ST_SCAN:  if (r_peak_vld_p2 && (r_peak_pix_p2 == PW'(NPIX - 1))) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state       <= ST_IDLE;
      r_seq         <= '0;
      r_scan_end    <= 1'b0;
      r_lcnt        <= '0;
      r_vld_p1      <= 1'b0;
      r_fwd_vld_p1  <= 1'b0;
      r_scan_vld_p1 <= 1'b0;
      r_peak_vld_p2 <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_CLEAR) || w_scan_rd) begin
        r_seq <= r_seq + AW'(1);
      end else if (r_state != ST_SCAN) begin
        r_seq <= '0;
      end
      r_scan_end <= (r_state == ST_SCAN) && (r_scan_end || (&r_seq));
      if (r_state == ST_CLEAR) begin
        r_lcnt <= '0;
      end else if ((r_state == ST_ACCUM) && laser_sync) begin
        r_lcnt <= r_lcnt + LW'(1);
      end
      r_vld_p1      <= w_s1_vld;
      r_fwd_vld_p1  <= w_s1_vld && r_vld_p1 && (w_s1_addr == r_addr_p1);
      r_scan_vld_p1 <= w_scan_rd;
      r_peak_vld_p2 <= w_pix_end;
    end
  end

  always_ff @(posedge clk) begin
    r_addr_p1      <= w_s1_addr;
    r_fwd_data_p1  <= w_inc;
    r_scan_addr_p1 <= r_seq;
    if (r_scan_vld_p1) begin
      r_max_cnt <= w_cand_cnt;
      r_max_bin <= w_cand_bin;
    end
    if (w_pix_end) begin
      r_peak_pix_p2 <= r_scan_addr_p1[AW-1:NP];
      r_peak_bin_p2 <= w_cand_bin;
      r_peak_cnt_p2 <= w_cand_cnt;
    end
  end

  assign gnt        = w_gnt;
  assign ram_we     = (r_state == ST_CLEAR) || r_vld_p1;
  assign ram_waddr  = (r_state == ST_CLEAR) ? r_seq : (r_vld_p1 ? r_addr_p1 : '0);
  assign ram_wdata  = (r_state == ST_CLEAR) ? '0 : (r_vld_p1 ? w_inc : '0);
  assign ram_re     = w_s1_vld || w_scan_rd;
  assign ram_raddr  = w_scan_rd ? r_seq : (w_s1_vld ? w_s1_addr : '0);
  assign peak_valid = r_peak_vld_p2;
  assign peak_pix   = r_peak_vld_p2 ? r_peak_pix_p2 : '0;
  assign peak_bin   = r_peak_vld_p2 ? r_peak_bin_p2 : '0;
  assign peak_cnt   = r_peak_vld_p2 ? r_peak_cnt_p2 : '0;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_sifh_acq_sched.sv
// Scoreboard bench for sifh_acq_sched with a read-first histogram RAM model.
module tb_sifh_acq_sched;

  localparam int NPIX = 4;
  localparam int NP   = 4;
  localparam int PM   = 4;
  localparam int ACQ  = 2;
  localparam int AW   = 6;

  logic            clk = 1'b0;
  logic            res, start, laser_sync;
  logic [3:0]      req;
  logic [15:0]     ts;
  logic [3:0]      gnt;
  logic [AW-1:0]   ram_waddr, ram_raddr;
  logic [PM-1:0]   ram_wdata, ram_rdata;
  logic            ram_we, ram_re;
  logic            peak_valid;
  logic [1:0]      peak_pix;
  logic [NP-1:0]   peak_bin;
  logic [PM-1:0]   peak_cnt;
  logic            busy, done;

  logic [PM-1:0]   mem [64];

  typedef struct {int pix; int bin; int cnt;} peak_t;
  peak_t exp_q[$];
  int    hist [4][16];
  int    n_checks = 0;
  int    n_errors = 0;

  sifh_acq_sched #(.NPIX(NPIX), .NP(NP), .PEAK_MAX(PM), .ACQ_NUM(ACQ)) dut (
    .clk(clk), .res(res), .start(start), .laser_sync(laser_sync),
    .req(req), .ts(ts), .gnt(gnt),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_rdata(ram_rdata),
    .peak_valid(peak_valid), .peak_pix(peak_pix), .peak_bin(peak_bin),
    .peak_cnt(peak_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_re) ram_rdata <= mem[ram_raddr];
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One ACCUM cycle: drive, check grant, account accepted hit in the model.
  task automatic cyc(input logic [3:0] rq, input logic [15:0] tsv,
                     input logic [3:0] exp_g, input string tag);
    int b;
    req = rq;
    ts  = tsv;
    #1;
    chk(tag, gnt, exp_g);
    for (int p = 0; p < NPIX; p++) begin
      if (exp_g[p]) begin
        b = int'(tsv[p*NP +: NP]);
        if (hist[p][b] < 15) hist[p][b]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic start_frame();
    for (int p = 0; p < NPIX; p++)
      for (int b = 0; b < 16; b++) hist[p][b] = 0;
    start = 1'b1;
    #1;
    chk("idle_busy", busy, 0);
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      #1;
      if (i == 0) chk("clear_busy", busy, 1);
      chk("clear_we", ram_we, 1);
      chk("clear_addr", ram_waddr, i);
      chk("clear_data", ram_wdata, 0);
      start = 1'b0;
      @(negedge clk);
    end
    #1;
    chk("accum_no_we", ram_we, 0);
  endtask

  task automatic push_peaks();
    peak_t e;
    for (int p = 0; p < NPIX; p++) begin
      e.pix = p; e.bin = 0; e.cnt = hist[p][0];
      for (int b = 1; b < 16; b++)
        if (hist[p][b] > e.cnt) begin e.bin = b; e.cnt = hist[p][b]; end
      exp_q.push_back(e);
    end
  endtask

  task automatic end_frame(input logic [3:0] rq1, input logic [15:0] ts1, input logic [3:0] g1,
                           input logic [3:0] rq2, input logic [15:0] ts2);
    int off, npk, ndone;
    peak_t e;
    laser_sync = 1'b1;
    cyc(rq1, ts1, g1, "sync1_gnt");
    laser_sync = 1'b0;
    cyc(4'b0000, 16'h0000, 4'b0000, "gap_gnt");
    push_peaks();
    laser_sync = 1'b1;
    cyc(rq2, ts2, 4'b0000, "term_gnt");
    laser_sync = 1'b0;
    req = 4'b0000;
    off = 1; npk = 0; ndone = 0;
    while (ndone == 0 && off < 200) begin
      #1;
      if (off == 1) chk("drain_busy", busy, 1);
      if (off == 2) begin
        chk("scan_re0", ram_re, 1);
        chk("scan_ra0", ram_raddr, 0);
      end
      if (peak_valid) begin
        if (exp_q.size() == 0) chk("peak_extra", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("peak_pix", peak_pix, e.pix);
          chk("peak_bin", peak_bin, e.bin);
          chk("peak_cnt", peak_cnt, e.cnt);
          chk("peak_time", off, 19 + 16*npk);
        end
        npk++;
      end
      if (done) begin
        ndone++;
        chk("done_time", off, 68);
      end
      @(negedge clk);
      off++;
    end
    chk("peak_count", npk, 4);
    chk("done_seen", ndone, 1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("done_once", done, 0);
      chk("post_busy", busy, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = PM'($urandom);
    res = 1'b1; start = 1'b0; laser_sync = 1'b0; req = '0; ts = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_re", ram_re, 0);
    chk("rst_done", done, 0);
    res = 1'b0;
    @(negedge clk);

    // Frame 1: rotation, forwarding, saturation, tie-break.
    start_frame();
    cyc(4'b1111, 16'h7777, 4'b0001, "rr0");
    cyc(4'b1111, 16'h7777, 4'b0010, "rr1");
    cyc(4'b1111, 16'h7777, 4'b0100, "rr2");
    cyc(4'b1111, 16'h7777, 4'b1000, "rr3");
    cyc(4'b1111, 16'h7777, 4'b0001, "rr4");
    repeat (3)  cyc(4'b0010, 16'h0050, 4'b0010, "fwd_gnt");
    repeat (20) cyc(4'b0100, 16'h0700, 4'b0100, "sat_gnt");
    repeat (4)  cyc(4'b0001, 16'h0003, 4'b0001, "tie3_gnt");
    repeat (4)  cyc(4'b0001, 16'h0009, 4'b0001, "tie9_gnt");
    end_frame(4'b1000, 16'h7000, 4'b1000, 4'b1111, 16'h7777);
    chk("ram21", mem[21], 3);
    chk("ram39", mem[39], 15);

    // Frame 2: reset mid-ACCUM with a write in flight.
    start_frame();
    cyc(4'b0010, 16'h0050, 4'b0010, "pre_rst_gnt");
    res = 1'b1;
    cyc(4'b0100, 16'h0300, 4'b0100, "rst_cyc_gnt");
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_re", ram_re, 0);
    chk("mid_rst_waddr", ram_waddr, 0);
    chk("mid_rst_raddr", ram_raddr, 0);
    chk("mid_rst_pv", peak_valid, 0);
    chk("mid_rst_done", done, 0);
    res = 1'b0;
    req = '0;
    @(negedge clk);

    // Frame 3: clean frame with empty pixels after the aborted one.
    start_frame();
    repeat (3) cyc(4'b0010, 16'h0050, 4'b0010, "f3_p1");
    cyc(4'b0110, 16'h0A50, 4'b0100, "f3_rr_a");
    cyc(4'b0110, 16'h0A50, 4'b0010, "f3_rr_b");
    cyc(4'b0100, 16'h0A00, 4'b0100, "f3_p2");
    end_frame(4'b0000, 16'h0000, 4'b0000, 4'b1001, 16'h3003);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sifh_acq_sched.md
# sifh_acq_sched

Acquisition scheduler for the SiFH histogram engine. It shares one simple dual-port histogram RAM between NPIX pixel timestamp streams, and sequences each frame through four phases: RAM clear, arbitrated accumulation over ACQ_NUM laser cycles, pipeline drain, and per-pixel peak scan. It sits between the pixel TDC front-ends and the peak-result consumer, and owns every RAM address and enable.

## Interface
- NPIX, 4: pixels sharing the RAM; power of two, ≥2; PW = log2(NPIX)
- NP, 10: timestamp/bin width; bins per pixel = 2^NP
- PEAK_MAX, 8: histogram count width; CMAX = 2^PEAK_MAX−1
- ACQ_NUM, 16: laser cycles per frame
- AW, PW+NP (derived): RAM address width; address = {pix, bin}

Ports:
- clk  in  1  clock; single domain
- res  in  1  reset; synchronous, active-high
- start  in  1  frame request; sampled only in IDLE
- laser_sync  in  1  one-cycle pulse per laser cycle
- req  in  NPIX  per-pixel timestamp valid
- ts  in  NPIX*NP  per-pixel timestamps; pixel i at [i*NP +: NP]
- gnt  out  NPIX  one-hot accept; the timestamp is consumed in that cycle
- ram_waddr  out  AW  write address
- ram_wdata  out  PEAK_MAX  write data
- ram_we  out  1  write enable
- ram_raddr  out  AW  read address
- ram_re  out  1  read enable
- ram_rdata  in  PEAK_MAX  read data; valid 1 cycle after ram_re; read-first on same-address collision
- peak_valid  out  1  one-cycle strobe per pixel
- peak_pix  out  PW  pixel index
- peak_bin  out  NP  bin of maximum count
- peak_cnt  out  PEAK_MAX  maximum count
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame end

## Operation
- States: IDLE → CLEAR → ACCUM → DRAIN → SCAN → DONE → IDLE.
- IDLE: all outputs 0. start=1 → CLEAR. start is ignored in every other state.
- CLEAR: writes 0 to addresses 0..2^AW−1, one per cycle, in ascending order. After the last address, go to ACCUM. Laser-cycle counter resets to 0.
- ACCUM, arbitration:
  - Round-robin among asserted req, at most one grant per cycle.
  - The pointer starts at pixel 0 and moves to (granted+1) mod NPIX after each grant.
- ACCUM, stage 1 (grant cycle): ram_re=1, ram_raddr={pix, ts[pix]}.
- ACCUM, stage 2 (next cycle):
  - ram_we=1 to the same address.
  - ram_wdata = min(old+1, CMAX), i.e. saturating.
- Forwarding: when a stage-1 address equals the address being written in stage 2 of the same cycle, stage 2 of the next cycle uses the forwarded written value instead of ram_rdata. Back-to-back hits on one bin must count exactly.
- laser_sync in ACCUM increments the counter. When the ACQ_NUM-th sync arrives, no grant is issued in that cycle; the FSM goes to DRAIN. laser_sync outside ACCUM is ignored.
- DRAIN: one cycle, which completes the outstanding stage 2. Then go to SCAN.
- SCAN, reads: reads addresses 0..2^AW−1 in ascending order, one per cycle.
- SCAN, maximum tracking:
  - Track the per-pixel maximum with strict `>`, so ties keep the lowest bin.
  - Running max resets to (bin 0, count from bin 0) at each pixel boundary.
  - An all-zero histogram reports bin 0, count 0.
- SCAN, output: after the rdata for bin 2^NP−1 of pixel p, assert peak_valid for one cycle with that pixel's result. After the last pixel's result, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- res in any state: IDLE on the next edge; all outputs 0; counters and arbiter pointer cleared. Any in-flight write is dropped and RAM contents are undefined. The next frame's CLEAR restores them.

## Timing
- CLEAR: 2^AW cycles. DRAIN: 1 cycle.
- Increment latency: the write occurs 1 cycle after gnt.
- Throughput: one timestamp per cycle in ACCUM.
- SCAN: the read of {p, b} is issued at SCAN cycle p·2^NP+b. peak_valid for pixel p is high at SCAN cycle (p+1)·2^NP+1.
- done is high 1 cycle after the last peak_valid.
- busy rises the cycle after start is accepted and falls with done.
- gnt is never asserted outside ACCUM, nor in the terminating laser_sync cycle.

## Structure
- Shared package sifh_pkg holds:
  - the state encoding
  - parameter defaults NPIX, NP, PEAK_MAX, ACQ_NUM
  - the AW derivation function
- One sub-module, sifh_rr_arb: NPIX-wide round-robin arbiter with one-hot grant and pointer update on grant.

## Test plan
Use NPIX=4, NP=4, PEAK_MAX=4, ACQ_NUM=2 throughout.
- Clear: after start, 64 writes of 0 to addresses 0..63, with busy=1 from the cycle after start → then ACCUM.
- Forwarding: pixel 1 sends ts=5 on 3 consecutive cycles → RAM[21]=3; peak (pix 1, bin 5, cnt 3).
- Arbitration and saturation:
  - All four req held with ts=7 → gnt rotates 0,1,2,3,0.
  - 20 hits on pixel 2, bin 7 → count saturates at 15.
- Ties and empty histograms:
  - Pixel 0 with bins 3 and 9 at count 4 → peak bin 3.
  - A pixel with no hits → bin 0, cnt 0.
- Frame end: the second laser_sync while req is high → no gnt in that cycle; DRAIN, then SCAN; 4 peak_valid strobes, 16 cycles apart; done pulses once.
- Reset: res asserted mid-ACCUM → next cycle all outputs 0, busy 0. A new start gives a correct clean frame.
